// File: rtl/ps2_cmd_pkg.sv
// Shared constants and types for the PS/2 command-line interpreter.
package ps2_cmd_pkg;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_S     = "S";
    localparam logic [7:0] ASC_E     = "E";
    localparam logic [7:0] ASC_T     = "T";
    localparam logic [7:0] ASC_F     = "F";
    localparam logic [7:0] ASC_I     = "I";
    localparam logic [7:0] ASC_R     = "R";

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        CONVERT,
        COMMIT,
        ERROR
    } state_t;

    // Defaults for the two-channel build: channel 0 = 'A' (70), channel 1 = 'V' (60).
    localparam logic [15:0] DEF_CH_LETTERS = {"V", "A"};
    localparam logic [63:0] DEF_RESET_VALS = {32'd60, 32'd70};

endpackage

// File: rtl/ps2_dec_accum.sv
// One decimal-accumulation step: classifies a character and computes acc*10 + digit.
module ps2_dec_accum
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned VAL_WIDTH = 32,
    parameter int unsigned MAX_VAL   = 99999
) (
    input  logic [VAL_WIDTH+3:0] acc,
    input  logic [7:0]           chr,
    output logic [VAL_WIDTH+3:0] next_acc,
    output logic                 is_digit,
    output logic                 is_term,
    output logic                 ovf
);

    localparam int unsigned AW = VAL_WIDTH + 4;
    localparam logic [AW-1:0] MAX_ACC = AW'(MAX_VAL);

    // Classify the character and form the shifted-add multiply by ten.
    always_comb begin
        is_digit = (chr >= ASC_0) && (chr <= ASC_9);
        is_term  = (chr == ASC_SPACE) || (chr == ASC_NUL);
        next_acc = (acc << 3) + (acc << 1) + AW'(chr[3:0]);
        ovf      = next_acc > MAX_ACC;
    end

endmodule

// File: rtl/ps2_cmd_interpreter.sv
// Parses "SET <letter> <digits>" and "FIRE" lines into per-channel value registers.
module ps2_cmd_interpreter
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned LINE_CHARS = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter logic [8*NUM_CH-1:0] CH_LETTERS = DEF_CH_LETTERS,
    parameter int unsigned VAL_WIDTH  = 32,
    parameter int unsigned MAX_DIGITS = 5,
    parameter int unsigned MAX_VAL    = 99999,
    parameter logic [NUM_CH*VAL_WIDTH-1:0] RESET_VALS = DEF_RESET_VALS
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [8*LINE_CHARS-1:0]       line_in,
    input  logic                          line_valid,
    output logic                          busy,
    output logic [NUM_CH*VAL_WIDTH-1:0]   values,
    output logic [NUM_CH-1:0]             upd,
    output logic                          fire,
    output logic                          err,
    output logic                          overrun
);

    localparam int unsigned LW    = 8 * LINE_CHARS;
    localparam int unsigned AW    = VAL_WIDTH + 4;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIG_W = $clog2(MAX_DIGITS + 1) + 1;
    localparam logic [DIG_W-1:0] MAX_DIG = DIG_W'(MAX_DIGITS);

    state_t            state, state_nxt;
    logic [LW-1:0]     line_buf;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     next_acc;
    logic [DIG_W-1:0]  dig_cnt;
    logic [CH_W-1:0]   ch_sel;
    logic [CH_W-1:0]   dec_ch;
    logic              dec_hit;
    logic              do_fire;
    logic              do_commit;
    logic              is_digit, is_term, ovf;
    logic [7:0]        c0, c1, c2, c3, c4, c5, cur;

    // The buffer is shifted left as characters are consumed, so the current
    // character is always the top byte and end-of-line reads as NUL.
    always_comb begin
        c0  = line_buf[LW-1  -: 8];
        c1  = line_buf[LW-9  -: 8];
        c2  = line_buf[LW-17 -: 8];
        c3  = line_buf[LW-25 -: 8];
        c4  = line_buf[LW-33 -: 8];
        c5  = line_buf[LW-41 -: 8];
        cur = c0;
    end

    ps2_dec_accum #(
        .VAL_WIDTH (VAL_WIDTH),
        .MAX_VAL   (MAX_VAL)
    ) u_accum (
        .acc      (acc),
        .chr      (cur),
        .next_acc (next_acc),
        .is_digit (is_digit),
        .is_term  (is_term),
        .ovf      (ovf)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic, channel-letter match and command decode.
    always_comb begin
        state_nxt = state;
        do_fire   = 1'b0;
        do_commit = 1'b0;
        dec_hit   = 1'b0;
        dec_ch    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!dec_hit && c4 == CH_LETTERS[8*i +: 8]) begin
                dec_hit = 1'b1;
                dec_ch  = CH_W'(i);
            end
        end
        case (state)
            IDLE: if (line_valid) state_nxt = DECODE;
            DECODE: begin
                if ({c0, c1, c2, c3} == {ASC_F, ASC_I, ASC_R, ASC_E} &&
                    (c4 == ASC_SPACE || c4 == ASC_NUL)) begin
                    do_fire   = 1'b1;
                    state_nxt = IDLE;
                end else if ({c0, c1, c2, c3} == {ASC_S, ASC_E, ASC_T, ASC_SPACE} &&
                             c5 == ASC_SPACE && dec_hit) begin
                    state_nxt = CONVERT;
                end else begin
                    state_nxt = ERROR;
                end
            end
            CONVERT: begin
                if (is_term) begin
                    if (dig_cnt == '0) begin
                        state_nxt = ERROR;
                    end else begin
                        do_commit = 1'b1;
                        state_nxt = COMMIT;
                    end
                end else if (!is_digit || dig_cnt == MAX_DIG || ovf) begin
                    state_nxt = ERROR;
                end
            end
            COMMIT:  state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line capture, digit accumulation, value registers and registered pulses.
    // The value register is loaded on the edge that enters COMMIT so the new
    // value and its upd pulse are visible in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_buf <= '0;
            acc      <= '0;
            dig_cnt  <= '0;
            ch_sel   <= '0;
            values   <= RESET_VALS;
            fire     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            fire    <= do_fire;
            overrun <= line_valid && (state != IDLE);
            case (state)
                IDLE: if (line_valid) line_buf <= line_in;
                DECODE: begin
                    line_buf <= line_buf << 48;
                    acc      <= '0;
                    dig_cnt  <= '0;
                    ch_sel   <= dec_ch;
                end
                CONVERT: begin
                    line_buf <= line_buf << 8;
                    if (is_digit) begin
                        acc     <= next_acc;
                        dig_cnt <= dig_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (do_commit) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == CH_W'(i)) values[VAL_WIDTH*i +: VAL_WIDTH] <= acc[VAL_WIDTH-1:0];
                end
            end
        end
    end

    // State-decoded status and pulse outputs.
    always_comb begin
        busy = (state != IDLE);
        err  = (state == ERROR);
        upd  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state == COMMIT && ch_sel == CH_W'(i)) upd[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_interpreter.sv
// Directed bench for ps2_cmd_interpreter: channel 0 = 'A' (reset 70), channel 1 = 'V' (reset 60).
module tb_ps2_cmd_interpreter;

    logic         clock;
    logic         reset_n;
    logic [255:0] line_in;
    logic         line_valid;
    logic         busy;
    logic [63:0]  values;
    logic [1:0]   upd;
    logic         fire;
    logic         err;
    logic         overrun;

    int vectors;
    int miscompares;

    ps2_cmd_interpreter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .line_in    (line_in),
        .line_valid (line_valid),
        .busy       (busy),
        .values     (values),
        .upd        (upd),
        .fire       (fire),
        .err        (err),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] mk(input string s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*(31-i) +: 8] = s[i];
        return r;
    endfunction

    // One-cycle strobe at a negedge; returns at the negedge after the capturing edge t.
    task automatic strobe(input string s);
        @(negedge clock);
        line_in    = mk(s);
        line_valid = 1'b1;
        @(negedge clock);
        line_valid = 1'b0;
        line_in    = '0;
    endtask

    // Observes 16 cycles after a strobe; *_at is the latency in cycles after t (-1 = never).
    task automatic watch(output int fire_at, output int upd_at, output int err_at,
                         output int vchg_at, output logic [1:0] upd_seen,
                         output int pulses, output logic busy_first);
        logic [63:0] snap;
        snap = values;
        fire_at = -1; upd_at = -1; err_at = -1; vchg_at = -1;
        upd_seen = '0; pulses = 0; busy_first = busy;
        for (int n = 0; n < 16; n++) begin
            if (n > 0) @(negedge clock);
            if (fire && fire_at < 0) fire_at = n + 1;
            if (upd != 2'b00 && upd_at < 0) begin upd_at = n + 1; upd_seen = upd; end
            if (err && err_at < 0) err_at = n + 1;
            if (values !== snap && vchg_at < 0) vchg_at = n + 1;
            pulses += int'(fire) + int'(upd != 2'b00) + int'(err);
        end
    endtask

    task automatic test_reset;
        vectors++; if (values !== {32'd60, 32'd70}) begin miscompares++; $display("FAIL reset_values: got %h want %h", values, {32'd60, 32'd70}); end
        vectors++; if ({busy, upd, fire, err, overrun} !== 6'b0) begin miscompares++; $display("FAIL reset_outputs: got %b want 000000", {busy, upd, fire, err, overrun}); end
    endtask

    task automatic test_set;
        int fa, ua, ea, va, p; logic [1:0] us; logic bf;
        strobe("SET A 45");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (bf !== 1'b1) begin miscompares++; $display("FAIL a45_busy_rise: got %b want 1", bf); end
        vectors++; if (ua !== 5 || us !== 2'b01) begin miscompares++; $display("FAIL a45_upd: got at %0d val %b want at 5 val 01", ua, us); end
        vectors++; if (va !== 5) begin miscompares++; $display("FAIL a45_value_latency: got %0d want 5", va); end
        vectors++; if (values !== {32'd60, 32'd45}) begin miscompares++; $display("FAIL a45_values: got %h want %h", values, {32'd60, 32'd45}); end
        vectors++; if (p !== 1 || ea !== -1 || fa !== -1) begin miscompares++; $display("FAIL a45_pulses: got %0d pulses err_at %0d fire_at %0d want 1 -1 -1", p, ea, fa); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL a45_idle_after: got %b want 0", busy); end

        strobe("SET V 99999");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ua !== 8 || us !== 2'b10) begin miscompares++; $display("FAIL v99999_upd: got at %0d val %b want at 8 val 10", ua, us); end
        vectors++; if (values !== {32'd99999, 32'd45}) begin miscompares++; $display("FAIL v99999_values: got %h want %h", values, {32'd99999, 32'd45}); end

        strobe("SET A 007");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ua !== 6 || values !== {32'd99999, 32'd7}) begin miscompares++; $display("FAIL a007: got at %0d values %h want at 6 values %h", ua, values, {32'd99999, 32'd7}); end

        strobe("SET A 12 9");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ua !== 5 || p !== 1 || values !== {32'd99999, 32'd12}) begin miscompares++; $display("FAIL a12_trailing: got at %0d pulses %0d values %h want at 5 pulses 1 values %h", ua, p, values, {32'd99999, 32'd12}); end
    endtask

    task automatic test_errors;
        int fa, ua, ea, va, p; logic [1:0] us; logic bf;
        strobe("SET V 100000");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea < 2 || ea > 9 || p !== 1 || ua !== -1) begin miscompares++; $display("FAIL v100000_err: got err_at %0d pulses %0d upd_at %0d want err_at<=9 pulses 1 upd_at -1", ea, p, ua); end
        vectors++; if (values !== {32'd99999, 32'd12}) begin miscompares++; $display("FAIL v100000_values: got %h want %h", values, {32'd99999, 32'd12}); end

        strobe("SET V 1x");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea < 2 || ea > 5 || p !== 1 || va !== -1) begin miscompares++; $display("FAIL v1x_err: got err_at %0d pulses %0d vchg %0d want err_at<=5 pulses 1 vchg -1", ea, p, va); end

        strobe("SET Q 5");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea !== 2 || p !== 1 || va !== -1) begin miscompares++; $display("FAIL q5_err: got err_at %0d pulses %0d vchg %0d want 2 1 -1", ea, p, va); end

        strobe("HELLO");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea !== 2 || p !== 1 || va !== -1) begin miscompares++; $display("FAIL hello_err: got err_at %0d pulses %0d vchg %0d want 2 1 -1", ea, p, va); end

        strobe("SET A ");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea !== 3 || p !== 1 || va !== -1) begin miscompares++; $display("FAIL nodigit_err: got err_at %0d pulses %0d vchg %0d want 3 1 -1", ea, p, va); end

        strobe("SET A 000000");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ea !== 8 || p !== 1 || va !== -1) begin miscompares++; $display("FAIL sixdigit_err: got err_at %0d pulses %0d vchg %0d want 8 1 -1", ea, p, va); end
        vectors++; if (values !== {32'd99999, 32'd12}) begin miscompares++; $display("FAIL errors_values: got %h want %h", values, {32'd99999, 32'd12}); end
    endtask

    task automatic test_fire;
        int fa, ua, ea, va, p; logic [1:0] us; logic bf;
        strobe("FIRE");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (fa !== 2 || ua !== -1 || ea !== -1 || p !== 1) begin miscompares++; $display("FAIL fire: got fire_at %0d upd_at %0d err_at %0d pulses %0d want 2 -1 -1 1", fa, ua, ea, p); end

        strobe("FIREX");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (fa !== -1 || ea !== 2) begin miscompares++; $display("FAIL firex: got fire_at %0d err_at %0d want -1 2", fa, ea); end
    endtask

    task automatic test_back_to_back;
        int ovr_cnt, ovr_at, upd_cnt, upd_at;
        ovr_cnt = 0; ovr_at = -1; upd_cnt = 0; upd_at = -1;
        strobe("SET A 123");
        for (int n = 0; n < 16; n++) begin
            if (n > 0) @(negedge clock);
            if (overrun) begin ovr_cnt++; if (ovr_at < 0) ovr_at = n + 1; end
            if (upd != 2'b00) begin upd_cnt++; if (upd_at < 0) upd_at = n + 1; end
            line_valid = (n == 1);
            line_in    = (n == 1) ? mk("SET V 7") : '0;
        end
        vectors++; if (ovr_cnt !== 1 || ovr_at !== 3) begin miscompares++; $display("FAIL overrun_pulse: got count %0d at %0d want 1 at 3", ovr_cnt, ovr_at); end
        vectors++; if (upd_cnt !== 1 || upd_at !== 6) begin miscompares++; $display("FAIL overrun_commit: got count %0d at %0d want 1 at 6", upd_cnt, upd_at); end
        vectors++; if (values !== {32'd99999, 32'd123}) begin miscompares++; $display("FAIL overrun_values: got %h want %h", values, {32'd99999, 32'd123}); end
    endtask

    task automatic test_reset_mid;
        int fa, ua, ea, va, p, late_upd; logic [1:0] us; logic bf;
        strobe("SET A 999");
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (values !== {32'd60, 32'd70} || busy !== 1'b0 || upd !== 2'b00) begin miscompares++; $display("FAIL midreset: got values %h busy %b upd %b want %h 0 00", values, busy, upd, {32'd60, 32'd70}); end
        @(negedge clock);
        reset_n = 1'b1;
        late_upd = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (upd != 2'b00 || busy) late_upd++;
        end
        vectors++; if (late_upd !== 0 || values !== {32'd60, 32'd70}) begin miscompares++; $display("FAIL midreset_no_commit: got activity %0d values %h want 0 %h", late_upd, values, {32'd60, 32'd70}); end

        strobe("SET A 0");
        watch(fa, ua, ea, va, us, p, bf);
        vectors++; if (ua !== 4 || us !== 2'b01 || values !== {32'd60, 32'd0}) begin miscompares++; $display("FAIL a0_after_reset: got at %0d upd %b values %h want at 4 upd 01 values %h", ua, us, values, {32'd60, 32'd0}); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        line_valid  = 1'b0;
        line_in     = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset;
        test_set;
        test_errors;
        test_fire;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
